// File: rtl/bp_be_hardfloat_pkg.sv
// FP types shared by the BE floating-point units.
// Adds the FCSR op/address encodings used by bp_be_fcsr_unit.
package bp_be_hardfloat_pkg;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } bsg_fp_eflags_s;

  typedef enum logic [2:0] {
    e_rne = 3'b000,
    e_rtz = 3'b001,
    e_rdn = 3'b010,
    e_rup = 3'b011,
    e_rmm = 3'b100,
    e_dyn = 3'b111
  } bsg_fp_rm_e;

  typedef enum logic [1:0] {
    e_fcsr_w = 2'd0,
    e_fcsr_s = 2'd1,
    e_fcsr_c = 2'd2,
    e_fcsr_r = 2'd3
  } bp_fcsr_op_e;

  typedef enum logic [1:0] {
    e_fflags = 2'd1,
    e_frm    = 2'd2,
    e_fcsr   = 2'd3
  } bp_fcsr_addr_e;

  function automatic logic [4:0] fcsr_apply(
    input bp_fcsr_op_e op,
    input logic [4:0]  old,
    input logic [4:0]  d
  );
    logic [4:0] r;
    r = old;
    case (op)
      e_fcsr_w: r = d;
      e_fcsr_s: r = old | d;
      e_fcsr_c: r = old & ~d;
      default:  r = old;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bp_be_fflags_pipe.sv
// One FP pipe's exception-flag delay line up to the commit point.
// Flush kills every in-flight entry, including the one being loaded.
module bp_be_fflags_pipe
  import bp_be_hardfloat_pkg::*;
#(
  parameter int commit_lat_p = 2
) (
  input  logic           clk_i,
  input  logic           reset_n_i,
  input  logic           flush_i,
  input  logic           v_i,
  input  bsg_fp_eflags_s flags_i,
  output logic           v_o,
  output bsg_fp_eflags_s flags_o
);

  logic [commit_lat_p-1:0]      v_q, v_d;
  logic [commit_lat_p-1:0][4:0] flags_q, flags_d;

  always_comb begin
    v_d        = v_q;
    flags_d    = flags_q;
    v_d[0]     = v_i;
    flags_d[0] = flags_i;
    for (int i = 1; i < commit_lat_p; i++) begin
      v_d[i]     = v_q[i-1];
      flags_d[i] = flags_q[i-1];
    end
    if (flush_i)
      v_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      v_q     <= '0;
      flags_q <= '0;
    end else begin
      v_q     <= v_d;
      flags_q <= flags_d;
    end
  end

  assign v_o     = v_q[commit_lat_p-1];
  assign flags_o = bsg_fp_eflags_s'(flags_q[commit_lat_p-1]);

endmodule

// File: rtl/bp_be_fcsr_unit.sv
// FP CSR unit: owns fflags/frm, accrues committed flags,
// serves CSR accesses and resolves dynamic rounding mode.
module bp_be_fcsr_unit
  import bp_be_hardfloat_pkg::*;
#(
  parameter int num_pipes_p  = 3,
  parameter int commit_lat_p = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [num_pipes_p-1:0]   flags_v_i,
  input  logic [5*num_pipes_p-1:0] flags_i,
  input  logic                     flush_i,
  input  logic                     csr_v_i,
  input  logic [1:0]               csr_op_i,
  input  logic [1:0]               csr_addr_i,
  input  logic [7:0]               csr_data_i,
  output logic [7:0]               csr_data_o,
  input  logic [2:0]               rm_i,
  output logic [2:0]               rm_o,
  output logic                     rm_illegal_o,
  output logic [4:0]               fflags_o,
  output logic [2:0]               frm_o,
  output logic                     dirty_o
);

  logic [num_pipes_p-1:0]      tail_v;
  logic [num_pipes_p-1:0][4:0] tail_flags;

  for (genvar p = 0; p < num_pipes_p; p++) begin : g_pipe
    bsg_fp_eflags_s tail_s;
    bp_be_fflags_pipe #(
      .commit_lat_p(commit_lat_p)
    ) u_pipe (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .flush_i  (flush_i),
      .v_i      (flags_v_i[p]),
      .flags_i  (bsg_fp_eflags_s'(flags_i[5*p+:5])),
      .v_o      (tail_v[p]),
      .flags_o  (tail_s)
    );
    assign tail_flags[p] = tail_s;
  end

  logic [4:0] fflags_q, fflags_d, fflags_csr, accrue;
  logic [2:0] frm_q, frm_d, frm_csr;
  logic       chg_q, chg_d;
  logic       dirty_q, dirty_d;
  logic [4:0] frm_ext;
  bp_fcsr_op_e op;

  assign op = bp_fcsr_op_e'(csr_op_i);

  always_comb begin
    accrue     = '0;
    fflags_csr = fflags_q;
    frm_ext    = {2'b00, frm_q};
    csr_data_o = '0;
    for (int p = 0; p < num_pipes_p; p++)
      if (tail_v[p])
        accrue = accrue | tail_flags[p];
    case (csr_addr_i)
      e_fflags: csr_data_o = {3'b000, fflags_q};
      e_frm:    csr_data_o = {5'b00000, frm_q};
      e_fcsr:   csr_data_o = {frm_q, fflags_q};
      default:  csr_data_o = '0;
    endcase
    if (csr_v_i) begin
      case (csr_addr_i)
        e_fflags: fflags_csr = fcsr_apply(op, fflags_q, csr_data_i[4:0]);
        e_frm: frm_ext = fcsr_apply(op, {2'b00, frm_q}, {2'b00, csr_data_i[2:0]});
        e_fcsr: begin
          fflags_csr = fcsr_apply(op, fflags_q, csr_data_i[4:0]);
          frm_ext = fcsr_apply(op, {2'b00, frm_q}, {2'b00, csr_data_i[7:5]});
        end
        default: ;
      endcase
    end
    frm_csr  = frm_ext[2:0];
    // CSR op belongs to a younger instr; committed flags still land on top
    fflags_d = fflags_csr | accrue;
    frm_d    = frm_csr;
    chg_d    = (fflags_d != fflags_q) || (frm_d != frm_q);
    dirty_d  = chg_q;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      fflags_q <= '0;
      frm_q    <= e_rne;
      chg_q    <= 1'b0;
      dirty_q  <= 1'b0;
    end else begin
      fflags_q <= fflags_d;
      frm_q    <= frm_d;
      chg_q    <= chg_d;
      dirty_q  <= dirty_d;
    end
  end

  always_comb begin
    rm_o         = (rm_i == e_dyn) ? frm_q : rm_i;
    rm_illegal_o = (rm_o == 3'b101) || (rm_o == 3'b110)
                || (rm_o == 3'b111);
  end

  assign fflags_o = fflags_q;
  assign frm_o    = frm_q;
  assign dirty_o  = dirty_q;

endmodule

// File: tb/tb_bp_be_fcsr_unit.sv
// Directed bench for bp_be_fcsr_unit (3 pipes, commit latency 2).
module tb_bp_be_fcsr_unit;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic [2:0]  flags_v_i;
  logic [14:0] flags_i;
  logic        flush_i;
  logic        csr_v_i;
  logic [1:0]  csr_op_i;
  logic [1:0]  csr_addr_i;
  logic [7:0]  csr_data_i;
  logic [7:0]  csr_data_o;
  logic [2:0]  rm_i;
  logic [2:0]  rm_o;
  logic        rm_illegal_o;
  logic [4:0]  fflags_o;
  logic [2:0]  frm_o;
  logic        dirty_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bp_be_fcsr_unit #(
    .num_pipes_p (3),
    .commit_lat_p(2)
  ) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n_i),
    .flags_v_i   (flags_v_i),
    .flags_i     (flags_i),
    .flush_i     (flush_i),
    .csr_v_i     (csr_v_i),
    .csr_op_i    (csr_op_i),
    .csr_addr_i  (csr_addr_i),
    .csr_data_i  (csr_data_i),
    .csr_data_o  (csr_data_o),
    .rm_i        (rm_i),
    .rm_o        (rm_o),
    .rm_illegal_o(rm_illegal_o),
    .fflags_o    (fflags_o),
    .frm_o       (frm_o),
    .dirty_o     (dirty_o)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr(input logic [1:0] op, input logic [1:0] addr,
                     input logic [7:0] d);
    csr_v_i    = 1'b1;
    csr_op_i   = op;
    csr_addr_i = addr;
    csr_data_i = d;
  endtask

  initial begin
    reset_n_i  = 1'b0;
    flags_v_i  = '0;
    flags_i    = '0;
    flush_i    = 1'b0;
    csr_v_i    = 1'b0;
    csr_op_i   = 2'd3;
    csr_addr_i = 2'd3;
    csr_data_i = '0;
    rm_i       = 3'd0;
    step();
    step();
    reset_n_i = 1'b1;
    chk("rst_fflags", {3'b0, fflags_o}, 8'h00);
    chk("rst_frm", {5'b0, frm_o}, 8'h00);
    chk("rst_dirty", {7'b0, dirty_o}, 8'h00);
    csr(2'd3, 2'd3, 8'h00);
    rm_i = 3'b111;
    #1;
    chk("rst_fcsr_rd", csr_data_o, 8'h00);
    chk("rst_rm_dyn", {5'b0, rm_o}, 8'h00);
    chk("rst_rm_ill", {7'b0, rm_illegal_o}, 8'h00);
    csr_v_i = 1'b0;

    // latency: pipe1 NX
    flags_v_i = 3'b010;
    flags_i   = 15'h0020;
    step();
    flags_v_i = '0;
    flags_i   = '0;
    chk("lat_t0", {3'b0, fflags_o}, 8'h00);
    step();
    chk("lat_t1", {3'b0, fflags_o}, 8'h00);
    step();
    chk("lat_t2", {3'b0, fflags_o}, 8'h01);
    chk("lat_t2_dirty", {7'b0, dirty_o}, 8'h00);
    step();
    chk("lat_t3_dirty", {7'b0, dirty_o}, 8'h01);
    step();
    chk("lat_t4_dirty", {7'b0, dirty_o}, 8'h00);

    csr(2'd0, 2'd1, 8'h00);
    step();
    csr_v_i = 1'b0;
    chk("wr_clr_ff", {3'b0, fflags_o}, 8'h00);
    step();
    step();

    // flush kills the entry still in stage 0
    flags_v_i = 3'b001;
    flags_i   = 15'h0010;
    step();
    flags_v_i = '0;
    flags_i   = '0;
    flush_i   = 1'b1;
    step();
    flush_i = 1'b0;
    step();
    step();
    chk("flush_kill", {3'b0, fflags_o}, 8'h00);

    // entry at tail during flush still commits; flush-cycle input dropped
    flags_v_i = 3'b001;
    flags_i   = 15'h0010;
    step();
    flags_v_i = '0;
    flags_i   = '0;
    step();
    flush_i   = 1'b1;
    flags_v_i = 3'b100;
    flags_i   = 15'h2000;
    step();
    flush_i   = 1'b0;
    flags_v_i = '0;
    flags_i   = '0;
    chk("flush_tail", {3'b0, fflags_o}, 8'h10);
    step();
    step();
    chk("flush_drop_in", {3'b0, fflags_o}, 8'h10);

    // invalid flags never accrue
    flags_i = 15'h7fff;
    step();
    step();
    step();
    flags_i = '0;
    chk("v0_ignored", {3'b0, fflags_o}, 8'h10);

    // clear collides with tail OF
    csr(2'd0, 2'd1, 8'h03);
    step();
    csr_v_i = 1'b0;
    chk("wr_ff3", {3'b0, fflags_o}, 8'h03);
    flags_v_i = 3'b001;
    flags_i   = 15'h0004;
    step();
    flags_v_i = '0;
    flags_i   = '0;
    step();
    csr(2'd2, 2'd1, 8'h03);
    #1;
    chk("coll_rd", csr_data_o, 8'h03);
    step();
    csr_v_i = 1'b0;
    chk("coll_ff", {3'b0, fflags_o}, 8'h04);

    csr(2'd1, 2'd1, 8'he1);
    step();
    csr_v_i = 1'b0;
    chk("set_ff", {3'b0, fflags_o}, 8'h05);

    csr(2'd0, 2'd3, 8'h5a);
    step();
    chk("fcsr_wr_ff", {3'b0, fflags_o}, 8'h1a);
    chk("fcsr_wr_frm", {5'b0, frm_o}, 8'h02);
    csr(2'd3, 2'd3, 8'hff);
    #1;
    chk("fcsr_rd", csr_data_o, 8'h5a);
    csr(2'd3, 2'd2, 8'hff);
    #1;
    chk("frm_rd", csr_data_o, 8'h02);
    step();
    chk("rd_nochg", {3'b0, fflags_o}, 8'h1a);

    // reserved frm is stored; dyn then illegal
    csr(2'd0, 2'd2, 8'hfd);
    step();
    csr_v_i = 1'b0;
    chk("frm_rsv", {5'b0, frm_o}, 8'h05);
    chk("frm_keep_ff", {3'b0, fflags_o}, 8'h1a);
    rm_i = 3'b111;
    #1;
    chk("dyn_rm", {5'b0, rm_o}, 8'h05);
    chk("dyn_ill", {7'b0, rm_illegal_o}, 8'h01);
    rm_i = 3'b001;
    #1;
    chk("rtz_rm", {5'b0, rm_o}, 8'h01);
    chk("rtz_ill", {7'b0, rm_illegal_o}, 8'h00);
    rm_i = 3'b110;
    #1;
    chk("rsv_rm", {5'b0, rm_o}, 8'h06);
    chk("rsv_ill", {7'b0, rm_illegal_o}, 8'h01);

    csr(2'd2, 2'd2, 8'h04);
    step();
    csr_v_i = 1'b0;
    chk("frm_clr", {5'b0, frm_o}, 8'h01);
    step();
    step();
    chk("same_val_dirty", {7'b0, dirty_o}, 8'h00);
    csr(2'd0, 2'd2, 8'h01);
    step();
    csr_v_i = 1'b0;
    step();
    step();
    chk("nochg_dirty", {7'b0, dirty_o}, 8'h00);

    // reset with flags in every stage
    flags_v_i = 3'b111;
    flags_i   = 15'h0421;
    step();
    step();
    flags_v_i = '0;
    flags_i   = '0;
    reset_n_i = 1'b0;
    step();
    reset_n_i = 1'b1;
    chk("mid_rst_ff", {3'b0, fflags_o}, 8'h00);
    chk("mid_rst_frm", {5'b0, frm_o}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_rst_after", {3'b0, fflags_o}, 8'h00);
      chk("mid_rst_dirty", {7'b0, dirty_o}, 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
